// File: rtl/rgs_pkg.sv
// Shared definitions for the timestamping register-bus master: register map,
// command encodings and sequencer states.
package rgs_pkg;

  localparam logic [7:0] CTL_TIME    = 8'h00;
  localparam logic [7:0] CTL_RX      = 8'h40;
  localparam logic [7:0] CTL_TX      = 8'h60;
  localparam logic [7:0] STAT_OFS    = 8'h04;
  localparam logic [7:0] DATA_OFS    = 8'h10;
  localparam logic [7:0] DATA_STRIDE = 8'h04;

  typedef enum logic [1:0] {
    OP_TIME = 2'd0,
    OP_RX   = 2'd1,
    OP_TX   = 2'd2,
    OP_ILL  = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CLR      = 4'd1,
    ST_STAT_RD  = 4'd2,
    ST_STAT_CAP = 4'd3,
    ST_SET      = 4'd4,
    ST_WAIT     = 4'd5,
    ST_POLL_RD  = 4'd6,
    ST_POLL_CAP = 4'd7,
    ST_DAT_RD   = 4'd8,
    ST_DAT_CAP  = 4'd9,
    ST_DONE     = 4'd10,
    ST_ILL      = 4'd11
  } state_e;

  function automatic logic [7:0] ctl_addr(input op_e op);
    case (op)
      OP_RX:   return CTL_RX;
      OP_TX:   return CTL_TX;
      default: return CTL_TIME;
    endcase
  endfunction

endpackage

// File: rtl/rgs_mst.sv
// Register-bus initiator for the timestamping register file: RTC snapshot and
// RX/TX queue pops. Optional poll timeout enabled by defining RGS_MST_TIMEOUT_EN.
module rgs_mst
  import rgs_pkg::*;
#(
  parameter int WAIT_CYC = 4,
  parameter int POLL_MAX = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  output logic         rsp_valid,
  output logic [127:0] rsp_data,
  output logic         rsp_empty,
  output logic         rsp_err,
  output logic         wr_out,
  output logic         rd_out,
  output logic [7:0]   addr_out,
  output logic [31:0]  data_out,
  input  logic [31:0]  data_in
);

  if (WAIT_CYC < 4 || WAIT_CYC > 256 || POLL_MAX < 1) begin : g_param_chk
    $error("rgs_mst: WAIT_CYC must be 4..256 and POLL_MAX must be >= 1");
  end

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYC - 1);

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic [7:0]     wait_q, wait_d;
  logic [1:0]     word_q, word_d;
  logic [127:0]   acc_q, acc_d;
  logic           done_empty, done_err;

  logic           cmd_ready_q, cmd_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [127:0]   rsp_data_q, rsp_data_d;
  logic           rsp_empty_q, rsp_empty_d;
  logic           rsp_err_q, rsp_err_d;
  logic           wr_q, wr_d;
  logic           rd_q, rd_d;
  logic [7:0]     addr_q, addr_d;
  logic [31:0]    data_q, data_d;
  logic [7:0]     ctl;
  logic [127:0]   time_word;

`ifdef RGS_MST_TIMEOUT_EN
  localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  logic [PW-1:0]  poll_q, poll_d;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_d     = wait_q;
    word_d     = word_q;
    acc_d      = acc_q;
    done_empty = 1'b0;
    done_err   = 1'b0;
`ifdef RGS_MST_TIMEOUT_EN
    poll_d     = poll_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d    = op_e'(cmd_op);
          state_d = (cmd_op == OP_ILL) ? ST_ILL : ST_CLR;
        end
      end
      ST_ILL: begin
        state_d  = ST_DONE;
        done_err = 1'b1;
      end
      ST_CLR:      state_d = (op_q == OP_TIME) ? ST_SET : ST_STAT_RD;
      ST_STAT_RD:  state_d = ST_STAT_CAP;
      ST_STAT_CAP: begin
        // An empty queue must not be popped, so the trigger is never raised.
        if (data_in[7:0] == 8'd0) begin
          state_d    = ST_DONE;
          done_empty = 1'b1;
        end else begin
          state_d = ST_SET;
        end
      end
      ST_SET: begin
        state_d = ST_WAIT;
        wait_d  = WAIT_LAST;
`ifdef RGS_MST_TIMEOUT_EN
        poll_d  = '0;
`endif
      end
      ST_WAIT: begin
        if (wait_q == 8'd0) state_d = ST_POLL_RD;
        else                wait_d  = wait_q - 8'd1;
      end
      ST_POLL_RD:  state_d = ST_POLL_CAP;
      ST_POLL_CAP: begin
        if (data_in[0]) begin
          state_d = ST_DAT_RD;
          word_d  = 2'd0;
        end else begin
`ifdef RGS_MST_TIMEOUT_EN
          if (poll_q == PW'(POLL_MAX - 1)) begin
            state_d  = ST_DONE;
            done_err = 1'b1;
          end else begin
            poll_d  = poll_q + 1'b1;
            state_d = ST_POLL_RD;
          end
`else
          state_d = ST_POLL_RD;
`endif
        end
      end
      ST_DAT_RD:   state_d = ST_DAT_CAP;
      ST_DAT_CAP: begin
        acc_d   = {acc_q[95:0], data_in};
        word_d  = word_q + 2'd1;
        state_d = (word_q == 2'd3) ? ST_DONE : ST_DAT_RD;
      end
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Bus and result registers are loaded from the next state so they line up
  // with the state they belong to.
  always_comb begin
    ctl         = ctl_addr(op_d);
    time_word   = {42'd0, acc_d[111:96], acc_d[95:64], acc_d[61:32], acc_d[7:0]};
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    addr_d      = 8'd0;
    data_d      = 32'd0;
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_empty_d = rsp_empty_q;
    rsp_err_d   = rsp_err_q;
    case (state_d)
      ST_CLR: begin
        wr_d   = 1'b1;
        addr_d = ctl;
      end
      ST_STAT_RD: begin
        rd_d   = 1'b1;
        addr_d = ctl + STAT_OFS;
      end
      ST_SET: begin
        wr_d   = 1'b1;
        addr_d = ctl;
        data_d = 32'd1;
      end
      ST_POLL_RD: begin
        rd_d   = 1'b1;
        addr_d = ctl;
      end
      ST_DAT_RD: begin
        rd_d   = 1'b1;
        addr_d = ctl + DATA_OFS + ({6'd0, word_d} * DATA_STRIDE);
      end
      ST_DONE: begin
        wr_d        = (op_d != OP_ILL);
        addr_d      = (op_d != OP_ILL) ? ctl : 8'd0;
        rsp_valid_d = 1'b1;
        rsp_empty_d = done_empty;
        rsp_err_d   = done_err;
        if (done_empty || done_err) rsp_data_d = 128'd0;
        else if (op_d == OP_TIME)   rsp_data_d = time_word;
        else                        rsp_data_d = acc_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_TIME;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 128'd0;
      rsp_empty_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= 8'd0;
      data_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_empty_q <= rsp_empty_d;
      rsp_err_q   <= rsp_err_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    wait_q <= wait_d;
    word_q <= word_d;
    acc_q  <= acc_d;
`ifdef RGS_MST_TIMEOUT_EN
    poll_q <= poll_d;
`endif
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_empty = rsp_empty_q;
  assign rsp_err   = rsp_err_q;
  assign wr_out    = wr_q;
  assign rd_out    = rd_q;
  assign addr_out  = addr_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_rgs_mst.sv
// Bench for rgs_mst: behavioural register-file target, bus-transaction log and
// a reference of expected bus sequences, payloads and latencies.
`timescale 1ns/1ps
module tb_rgs_mst;
  localparam int WAIT_CYC = 4;
  localparam int POLL_MAX = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic [1:0]   cmd_op = 2'd0;
  logic         cmd_ready, rsp_valid, rsp_empty, rsp_err, wr_out, rd_out;
  logic [127:0] rsp_data;
  logic [7:0]   addr_out;
  logic [31:0]  data_out;
  logic [31:0]  data_in = 32'd0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rgs_mst #(.WAIT_CYC(WAIT_CYC), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_empty(rsp_empty), .rsp_err(rsp_err),
    .wr_out(wr_out), .rd_out(rd_out), .addr_out(addr_out), .data_out(data_out),
    .data_in(data_in)
  );

  // Behavioural target: memory plus a CTL ok-flag that rises after ok_after polls.
  logic [31:0] mem [256];
  int  ok_after = 1;
  int  polls = 0;
  bit  armed = 1'b0;

  function automatic bit is_ctl(input logic [7:0] a);
    return (a == 8'h00) || (a == 8'h40) || (a == 8'h60);
  endfunction

  always @(posedge clk) begin
    logic [31:0] v;
    v = $urandom;
    if (rd_out) begin
      if (is_ctl(addr_out)) begin
        polls = polls + 1;
        v[0] = armed && (ok_after != 0) && (polls >= ok_after);
      end else begin
        v = mem[addr_out];
      end
    end
    data_in <= v;
    if (wr_out && is_ctl(addr_out)) begin
      armed = data_out[0];
      polls = 0;
    end
  end

  // Bus log: {is_write, addr, wdata}
  logic [40:0] log_q [$];
  logic [40:0] exp_q [$];
  int rsp_cnt = 0;
  int idle_bad = 0;

  always @(negedge clk) begin
    if (wr_out) log_q.push_back({1'b1, addr_out, data_out});
    if (rd_out) log_q.push_back({1'b0, addr_out, 32'd0});
    if (wr_out && rd_out) idle_bad++;
    if (!wr_out && !rd_out && (addr_out != 8'd0 || data_out != 32'd0)) idle_bad++;
    if (rsp_valid) rsp_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_log(input string tag);
    chk({tag, " bus_len"}, 128'(log_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s bus[%0d]", tag, i), 128'(log_q[i]), 128'(exp_q[i]));
  endtask

  task automatic chk_quiet(input string tag, input logic ready_exp);
    chk({tag, " cmd_ready"}, 128'(cmd_ready), 128'(ready_exp));
    chk({tag, " strobes"},   128'({wr_out, rd_out, rsp_valid, rsp_empty, rsp_err}), 128'd0);
    chk({tag, " addr_data"}, 128'({addr_out, data_out}), 128'd0);
    chk({tag, " rsp_data"},  rsp_data, 128'd0);
  endtask

  function automatic logic [7:0] ctl_of(input logic [1:0] op);
    return (op == 2'd1) ? 8'h40 : (op == 2'd2) ? 8'h60 : 8'h00;
  endfunction

  // Loads the target with a time snapshot; unused bits carry junk.
  task automatic setup_time(input logic [47:0] sec, input logic [37:0] ns,
                            output logic [127:0] expv);
    logic [31:0] j;
    j = $urandom; mem[8'h10] = {j[31:16], sec[47:32]};
    mem[8'h14] = sec[31:0];
    j = $urandom; mem[8'h18] = {j[31:30], ns[37:8]};
    j = $urandom; mem[8'h1C] = {j[31:8], ns[7:0]};
    expv = {42'd0, sec, ns};
  endtask

  task automatic setup_queue(input logic [1:0] op, input logic [7:0] stat,
                             input logic [127:0] words, output logic [127:0] expv);
    logic [31:0] j;
    logic [7:0]  c;
    c = ctl_of(op);
    j = $urandom; j[7:0] = stat; mem[c + 8'h04] = j;
    for (int i = 0; i < 4; i++) mem[c + 8'h10 + 8'(4 * i)] = words[127 - 32 * i -: 32];
    expv = words;
  endtask

  task automatic start_cmd(input logic [1:0] op);
    int g;
    g = 0;
    @(negedge clk);
    while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
    chk("cmd_ready_before_cmd", 128'(cmd_ready), 128'd1);
    log_q.delete();
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
  endtask

  task automatic wait_rsp(input int max_cyc, output int lat);
    int k;
    k = 1;
    while (!rsp_valid && k < max_cyc) begin @(posedge clk); #1; k++; end
    lat = rsp_valid ? k : -1;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input int npoll,
                        input bit empty, input logic [127:0] exp_data);
    int lat, explat, base;
    logic [7:0] c;
    c = ctl_of(op);
    exp_q.delete();
    ok_after = npoll;
    if (op == 2'd3) begin
      explat = 2;
    end else begin
      exp_q.push_back({1'b1, c, 32'd0});
      if (op != 2'd0) exp_q.push_back({1'b0, c + 8'h04, 32'd0});
      if (!empty) begin
        exp_q.push_back({1'b1, c, 32'd1});
        repeat (npoll) exp_q.push_back({1'b0, c, 32'd0});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, c + 8'h10 + 8'(4 * i), 32'd0});
      end
      exp_q.push_back({1'b1, c, 32'd0});
      explat = 1 + ((op != 2'd0) ? 2 : 0) + (empty ? 0 : (1 + WAIT_CYC + 2 * npoll + 8)) + 1;
    end
    base = rsp_cnt;
    start_cmd(op);
    wait_rsp(300, lat);
    chk({tag, " latency"}, 128'(lat), 128'(explat));
    chk({tag, " rsp_err"}, 128'(rsp_err), 128'(op == 2'd3));
    chk({tag, " rsp_empty"}, 128'(rsp_empty), 128'(empty && op != 2'd3));
    if (op != 2'd3) chk({tag, " rsp_data"}, rsp_data, empty ? 128'd0 : exp_data);
    @(posedge clk); #1;
    chk({tag, " single_pulse"}, 128'(rsp_cnt - base), 128'd1);
    chk({tag, " rsp_hold"}, 128'({rsp_valid, rsp_err}), 128'({1'b0, op == 2'd3}));
    chk_log(tag);
  endtask

  initial begin
    logic [127:0] e;
    logic [1:0]   op;
    logic [7:0]   stat;
    int           lat, base, n_rd;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset", 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 128'(cmd_ready), 128'd1);

    setup_time(48'h1234_89AB_CDEF, 38'h3F_FFFF_FF80, e);
    run_op("time_dir", 2'd0, 2, 1'b0, e);
    setup_queue(2'd1, 8'h03, 128'hA0A00001_A0A00002_A0A00003_A0A00004, e);
    run_op("rx_dir", 2'd1, 1, 1'b0, e);
    setup_queue(2'd2, 8'h00, {4{$urandom}}, e);
    run_op("tx_empty", 2'd2, 1, 1'b1, e);
    run_op("illegal", 2'd3, 1, 1'b0, 128'd0);

    for (int it = 0; it < 10; it++) begin
      op = 2'($urandom_range(0, 3));
      stat = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (op == 2'd0) begin
        setup_time({$urandom, $urandom}, {$urandom, $urandom}, e);
        run_op($sformatf("rnd%0d_time", it), op, $urandom_range(1, 3), 1'b0, e);
      end else if (op == 2'd3) begin
        run_op($sformatf("rnd%0d_ill", it), op, 1, 1'b0, 128'd0);
      end else begin
        setup_queue(op, stat, {$urandom, $urandom, $urandom, $urandom}, e);
        run_op($sformatf("rnd%0d_q%0d", it, op), op, $urandom_range(1, 3), stat == 8'd0, e);
      end
    end

    // Reset while waiting before the first poll
    setup_time({$urandom, $urandom}, {$urandom, $urandom}, e);
    ok_after = 1;
    base = rsp_cnt;
    start_cmd(2'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_quiet("mid_reset", 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_reset ready", 128'(cmd_ready), 128'd1);
    chk("mid_reset no_rsp", 128'(rsp_cnt - base), 128'd0);
    exp_q.delete();
    exp_q.push_back({1'b1, 8'h00, 32'd0});
    exp_q.push_back({1'b1, 8'h00, 32'd1});
    chk_log("mid_reset");
    setup_time(48'hFFFF_0000_5A5A, 38'h00_1234_5678, e);
    run_op("after_reset", 2'd0, 2, 1'b0, e);

    // Target that never reports ok
    ok_after = 0;
    base = rsp_cnt;
`ifdef RGS_MST_TIMEOUT_EN
    start_cmd(2'd0);
    wait_rsp(300, lat);
    chk("timeout latency", 128'(lat), 128'(1 + 1 + WAIT_CYC + 2 * POLL_MAX + 1));
    chk("timeout rsp_err", 128'(rsp_err), 128'd1);
    chk("timeout rsp_empty", 128'(rsp_empty), 128'd0);
    chk("timeout rsp_data", rsp_data, 128'd0);
    @(posedge clk); #1;
    chk("timeout single_pulse", 128'(rsp_cnt - base), 128'd1);
    exp_q.delete();
    exp_q.push_back({1'b1, 8'h00, 32'd0});
    exp_q.push_back({1'b1, 8'h00, 32'd1});
    repeat (POLL_MAX) exp_q.push_back({1'b0, 8'h00, 32'd0});
    exp_q.push_back({1'b1, 8'h00, 32'd0});
    chk_log("timeout");
`else
    start_cmd(2'd0);
    repeat (1000) @(posedge clk);
    #1;
    chk("nopoll_timeout no_rsp", 128'(rsp_cnt - base), 128'd0);
    chk("nopoll_timeout busy", 128'(cmd_ready), 128'd0);
    n_rd = 0;
    foreach (log_q[i]) if (!log_q[i][40]) n_rd++;
    chk("nopoll_timeout polling", 128'(n_rd >= 450), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
`endif
    setup_queue(2'd2, 8'h01, 128'h11112222_33334444_55556666_77778888, e);
    run_op("final_tx", 2'd2, 3, 1'b0, e);

    chk("bus_idle_rules", 128'(idle_bad), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
